// File: rtl/pipe_stage_skid_reg_if.sv
// pipe_stage_skid_reg_if: valid/ready/data handshake bundle for one side of a pipeline stage.
interface pipe_stage_skid_reg_if #(parameter int DATA_W = 32);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with registered ready, 2-entry skid buffer,
// flush, optional bubble zeroing, occupancy report and saturating stall counter.
module pipe_stage_skid_reg #(
    parameter int DATA_W      = 32,
    parameter bit BUBBLE_ZERO = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_stage_skid_reg_if.slave  in_if,
    pipe_stage_skid_reg_if.master out_if,
    input  logic                  flush_i,
    input  logic                  cnt_clr_i,
    output logic [1:0]            occupancy_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready, out_valid, accept, drain;
    assign accept = in_if.valid & in_ready;
    assign drain  = out_valid & out_if.ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end
    // A flushed accept is dropped; a flushed drain was already delivered this cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE_ZERO ? '0 : main_q;
            skid_d  = BUBBLE_ZERO ? '0 : skid_q;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    main_d  = in_if.data;
                end
                ONE: if (accept && drain) begin
                    main_d = in_if.data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_if.data;
                end else if (drain) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_ZERO ? '0 : main_q;
                end
                FULL: if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = BUBBLE_ZERO ? '0 : skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        cnt_d = cnt_clr_i ? '0
              : (out_valid && !out_if.ready && cnt_q != '1) ? cnt_q + CNT_W'(1)
              : cnt_q;
    end
    always_comb begin
        in_ready  = state_q != FULL;
        out_valid = state_q != EMPTY;
    end
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign occupancy_o  = state_q;
    assign stall_cnt_o  = cnt_q;
endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register for the pipelined processor datapath (ID/IX, IX/MEM, MEM/WB and similar boundaries).
- Replaces the fixed-field stall/flush latch with a generic payload, a valid/ready handshake and a 2-entry skid buffer.
- A stall therefore holds the instruction in the stage instead of destroying it, and ready is fully registered (no combinational ready path through the stage).
- Adds selectable bubble zeroing, flush, occupancy reporting and a saturating stall-cycle counter.

Parameters:
DATA_W, 32, payload width in bits (packed PC/IR/operands/control fields).
BUBBLE_ZERO, 1, 1 = main and skid payload registers are forced to 0 whenever their entry becomes invalid; 0 = payload registers keep their last value.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream has a payload.
in_data  input  DATA_W  upstream payload.
in_ready  output  1  stage can accept; registered.
out_valid  output  1  main entry holds a payload.
out_data  output  DATA_W  main entry payload; registered.
out_ready  input  1  downstream accepts.
flush  input  1  synchronous kill of all held entries.
cnt_clr  input  1  synchronous clear of stall_cnt.
occupancy  output  2  entries held: 0, 1 or 2.
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): state EMPTY; out_valid=0, in_ready=1, occupancy=0, out_data=0, skid payload=0, stall_cnt=0. Reset asserted mid-transfer discards all entries. There is no partial hold.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, main entry valid, in_ready 1.
  - FULL: occupancy 2, main and skid valid, in_ready 0.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE: accept & drain -> ONE, main<=in_data. accept & !drain -> FULL, skid<=in_data. !accept & drain -> EMPTY. Otherwise hold.
  - FULL: drain -> ONE, main<=skid. Otherwise hold. in_valid is ignored while in FULL.
- Latency: 1 cycle from accept in EMPTY to out_valid=1. Sustained throughput is 1 payload/cycle when out_ready stays 1.
- Ordering: strict FIFO. Payloads are never duplicated or dropped except by flush/reset.
- in_ready, out_valid and occupancy are decoded from registered state only. No combinational path from out_ready or in_valid to any output.
- flush (priority over everything except reset): next state EMPTY.
  - Any same-cycle accept is consumed upstream and discarded; it is not stored.
  - Any same-cycle drain still counts as delivered downstream, because out_data is valid that cycle.
  - With BUBBLE_ZERO=1, main and skid payloads are cleared to 0.
- BUBBLE_ZERO=1: on any transition to EMPTY, main payload <=0. On FULL->ONE, skid payload <=0. out_data is therefore 0 whenever out_valid=0.
- stall_cnt:
  - Increments by 1 each cycle out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment: the counter goes to 0 that edge.
  - Unaffected by flush.

Test Plan:
- Stream: release reset, in_valid=1 with in_data=1,2,3,...,8 on consecutive cycles, out_ready=1. Required: out_data=1..8 on consecutive cycles starting 1 cycle after first accept; in_ready stays 1; occupancy=1 throughout; stall_cnt=0.
- Backpressure: hold out_ready=0, present 0xA then 0xB. Required: occupancy 1 then 2, in_ready=0 after the second accept, 0xC held on in_data not accepted. Raise out_ready: out_data=0xA, 0xB, then 0xC in order; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush while FULL with simultaneous in_valid=1 and in_data=0x55, BUBBLE_ZERO=1. Required: next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; 0x55 never appears on out_data.
- Counter saturation, CNT_W=4: out_valid held with out_ready=0 for 20 cycles. Required: stall_cnt stops at 15. Assert cnt_clr together with a stall cycle: stall_cnt=0 next cycle, then increments to 1.
- Asynchronous reset mid-operation: in FULL, drop rst_n between clock edges. Required: outputs reach reset values immediately, without a clock edge. After release, first accepted payload 0x77 appears 1 cycle later with occupancy=1.
- BUBBLE_ZERO=0: accept 0x3C, drain it, then idle. Required: out_valid=0 and out_data remains 0x3C; the next accept of 0x3D overwrites it normally.
